// File: rtl/direction_uart_tx.sv
// Debounces the per-line classifier command and sends each newly stable command
// to the robot as a 3-byte UART 8N1 packet: 0xAA, cmd, ~cmd.
module direction_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int STABLE_LINES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       href,
  input  logic [2:0] direction,
  input  logic       orange_detected,
  output logic       tx,
  output logic       busy,
  output logic       cmd_sent,
  output logic [7:0] last_cmd
);

  localparam int SW = $clog2(STABLE_LINES + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_LINES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    CMD_STOP = 8'h58;
  localparam logic [7:0]    SYNC     = 8'hAA;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    cmd_now;
  logic          eol;
  logic          href_d_q;
  logic [7:0]    cand_q;
  logic [SW-1:0] stab_cnt_q;

  state_t        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    bit_nxt;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [7:0]    pkt_q, pkt_d;
  logic [7:0]    last_cmd_q, last_cmd_d;
  logic          tx_q, tx_d;
  logic          cmd_sent_q, cmd_sent_d;
  logic [7:0]    cur_byte;
  logic          bit_end;
  logic          launch;

  always_comb begin
    cmd_now = CMD_STOP;
    if (orange_detected) begin
      case (direction)
        3'b001:  cmd_now = 8'h4C;
        3'b010:  cmd_now = 8'h52;
        3'b011:  cmd_now = 8'h46;
        3'b100:  cmd_now = 8'h66;
        default: cmd_now = CMD_STOP;
      endcase
    end
  end

  assign eol = href_d_q & ~href;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      href_d_q   <= 1'b0;
      cand_q     <= CMD_STOP;
      stab_cnt_q <= '0;
    end else begin
      href_d_q <= href;
      if (eol) begin
        if (cmd_now == cand_q) begin
          if (stab_cnt_q != STAB_MAX) stab_cnt_q <= stab_cnt_q + SW'(1);
        end else begin
          cand_q     <= cmd_now;
          stab_cnt_q <= SW'(1);
        end
      end
    end
  end

  // Launch sees the pre-update cand/stab_cnt when an eol lands in the same cycle.
  assign launch  = (state_q == IDLE) && (stab_cnt_q == STAB_MAX) && (cand_q != last_cmd_q);
  assign bit_end = (clk_cnt_q == CNT_MAX);
  assign bit_nxt = bit_idx_q + 3'd1;

  always_comb begin
    case (byte_idx_q)
      2'd1:    cur_byte = pkt_q;
      2'd2:    cur_byte = ~pkt_q;
      default: cur_byte = SYNC;
    endcase
  end

  // tx_d is the line level for the state being entered, so tx stays aligned with busy.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    clk_cnt_d  = bit_end ? '0 : clk_cnt_q + CW'(1);
    pkt_d      = pkt_q;
    last_cmd_d = last_cmd_q;
    tx_d       = tx_q;
    cmd_sent_d = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        clk_cnt_d = '0;
        if (launch) begin
          state_d    = START;
          byte_idx_d = 2'd0;
          pkt_d      = cand_q;
          last_cmd_d = cand_q;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = cur_byte[bit_nxt];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q < 2'd2) begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
          end else begin
            state_d    = IDLE;
            cmd_sent_d = 1'b1;
            tx_d       = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      clk_cnt_q  <= '0;
      pkt_q      <= '0;
      last_cmd_q <= CMD_STOP;
      tx_q       <= 1'b1;
      cmd_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      clk_cnt_q  <= clk_cnt_d;
      pkt_q      <= pkt_d;
      last_cmd_q <= last_cmd_d;
      tx_q       <= tx_d;
      cmd_sent_q <= cmd_sent_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign cmd_sent = cmd_sent_q;
  assign last_cmd = last_cmd_q;

endmodule

// File: doc/direction_uart_tx.md
# direction_uart_tx

Transmit-side counterpart of the pixel classifier. It samples the classifier's `direction`/`orange_detected` result once per camera line and requires the same command for `STABLE_LINES` consecutive lines. When a stable command differs from the last one sent, it serialises a 3-byte command packet over a UART 8N1 link to the robot controller. It sits between the camera classification path and the robot's serial port, and runs in the camera pixel-clock domain.

## Interface
- `CLKS_PER_BIT`, default 217: clock cycles per UART bit; must be at least 2.
- `STABLE_LINES`, default 8: consecutive identical line samples required before a command counts as stable; must be at least 1.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `href` input, 1 bit: camera line-valid; a falling edge marks the end of a line.
- `direction` input, 3 bits: classifier direction code.
- `orange_detected` input, 1 bit: classifier target-present flag.
- `tx` output, 1 bit: UART serial line; idles high.
- `busy` output, 1 bit: high while a packet is being shifted out.
- `cmd_sent` output, 1 bit: one-cycle pulse when a packet has been transmitted completely.
- `last_cmd` output, 8 bits: command byte of the most recently launched packet.

## Operation
- **Command mapping (combinational, `cmd_now`)**
  - If `orange_detected` is 0, `cmd_now` is 0x58 ('X', stop).
  - Otherwise: `direction` 001 gives 0x4C ('L'); 010 gives 0x52 ('R'); 011 gives 0x46 ('F', fast); 100 gives 0x66 ('f', slow).
  - Any other `direction` code gives 0x58.
- **Line sampling**
  - `href` is registered as `href_d`. The line-end strobe `eol = href_d & ~href`.
  - On `eol`, if `cmd_now == cand`: `stab_cnt` increments, saturating at `STABLE_LINES`.
  - On `eol`, if `cmd_now != cand`: `cand <= cmd_now` and `stab_cnt <= 1`.
  - `stab_cnt` is `$clog2(STABLE_LINES+1)` bits wide.
- **Launch condition:** `stab_cnt == STABLE_LINES`, `cand != last_cmd`, and FSM in IDLE, all evaluated in the same cycle.
  - On launch, `last_cmd <= cand` and the packet is latched.
  - Packet byte 0 is 0xAA, byte 1 is `cand`, byte 2 is `~cand`.
  - Sampling continues during transmission. A command that becomes stable while the FSM is busy launches on the first IDLE cycle in which the condition still holds. There is no queue: only the current `cand` is ever sent.
- **Transmit FSM states:** IDLE, START, DATA, STOP. It also keeps a 2-bit byte index, a 3-bit bit index, and a bit-period counter that counts 0..`CLKS_PER_BIT`-1.
  - IDLE: `tx` = 1. On launch, go to START with byte index 0.
  - START: `tx` = 0 for one bit period, then go to DATA with bit index 0.
  - DATA: `tx` = current byte, LSB first, one bit period per bit. After bit 7, go to STOP.
  - STOP: `tx` = 1 for one bit period.
    - Then, if byte index is below 2, increment it and go to START. No idle gap is inserted between bytes.
    - Otherwise go to IDLE and pulse `cmd_sent`.
- **Outputs:** `busy` = (state != IDLE). `tx` is driven from a register, so it is glitch-free.
- **Reset values:** `tx` = 1, `busy` = 0, `cmd_sent` = 0, `last_cmd` = 0x58, `cand` = 0x58, `stab_cnt` = 0, `href_d` = 0, FSM in IDLE, all counters 0.
  - Because `last_cmd` resets to 0x58, a stable stop command after reset sends nothing.

## Timing
- **Launch latency**
  - The `eol` on which `stab_cnt` reaches `STABLE_LINES` falls on the cycle after `href` is sampled low.
  - Launch happens in the next cycle, and `tx` goes low on the cycle after launch.
  - Total: 3 cycles from the first low-sampled `href` edge to `tx` low, when the FSM is idle.
- **Packet duration:** exactly 30 × `CLKS_PER_BIT` cycles of `busy` high.
- **`cmd_sent`:** high for exactly one cycle, the cycle in which `busy` first reads 0 again. A new launch may coincide with that cycle.
- **Simultaneous events**
  - `eol` arriving in the same cycle as launch evaluation: the launch uses the pre-update `cand`/`stab_cnt`.
  - Reset coinciding with `eol` or any FSM state: reset wins.
- **Reset mid-packet:** `tx` is high on the next edge and the packet is abandoned; no `cmd_sent` is produced.
- **Constant `href`:** no `eol` occurs, so no new samples are taken. A pending stable command can still launch once the FSM returns to IDLE.

## Test plan
Unless a line says otherwise, parameters are `CLKS_PER_BIT`=4 and `STABLE_LINES`=3.

1. **Reset:** hold `rst_n`=0 for 5 cycles, then release → `tx`=1, `busy`=0, `cmd_sent`=0, `last_cmd`=0x58, and no activity for 200 cycles with `href` toggling and `orange_detected`=0.
2. **Basic send:** 3 lines with `orange_detected`=1, `direction`=001 → one packet on `tx`.
   - Decoded bytes are 0xAA, 0x4C, 0xB3, LSB first, each with a start and a stop bit.
   - `busy` is high for 120 cycles, `cmd_sent` pulses once, and `last_cmd` = 0x4C.
3. **Instability:** a line sequence 001, 001, 010, 001, 001 → no packet. `stab_cnt` is 2 at the end.
4. **Change during busy:** 3 lines of 001 launch 'L'. During that packet, 3 lines of 011 follow → 'L' completes, then an 'F' packet (0xAA, 0x46, 0xB9) starts on the `cmd_sent` cycle or within 1 cycle of it.
5. **Repeat and stop:** after 'L' has been sent, 10 more lines of 001 → no packet. Then 3 lines with `orange_detected`=0 → packet 0xAA, 0x58, 0xA7.
6. **Reset mid-packet:** assert `rst_n`=0 during the DATA state of byte 1 → `tx`=1 on the next edge, no `cmd_sent`, and `last_cmd`=0x58.
